// File: rtl/rv_pipeline_pkg.sv
// Constants shared by the RISC-V pipeline stages.
package rv_pipeline_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/pc_next_gen.sv
// Next-PC selection: redirect beats stall, stall beats sequential increment.
module pc_next_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misaligned_o
);
  import rv_pipeline_pkg::*;

  // Priority mux; redirect targets are forced to a word boundary.
  always_comb begin
    pc_next_o = pc_i + XLEN'(PC_STEP);
    if (redirect_i) begin
      pc_next_o = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (stall_i) begin
      pc_next_o = pc_i;
    end
  end

  assign misaligned_o = redirect_i & (|redirect_pc_i[1:0]);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, fetch address and IF/ID pipeline register.
module if_fetch_stage #(
  parameter int unsigned     XLEN       = rv_pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(rv_pipeline_pkg::RESET_PC),
  parameter int unsigned     IMEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic [31:0]     imem_instruction_i,
  output logic [XLEN-1:0] imem_pc_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [31:0]     ifid_instr_o,
  output logic            ifid_valid_o,
  output logic            fetch_fault_o
);
  import rv_pipeline_pkg::*;

  // One extra bit so the byte limit never overflows the compare.
  localparam logic [XLEN:0] IMEM_LIMIT = (XLEN+1)'(IMEM_WORDS) << 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            fault_q, fault_d;
  logic            misaligned;
  logic            out_of_range;
  logic            squash;

  pc_next_gen #(
    .XLEN (XLEN)
  ) u_pc_next_gen (
    .pc_i          (pc_q),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_next_o     (pc_d),
    .misaligned_o  (misaligned)
  );

  assign out_of_range = {1'b0, pc_q} >= IMEM_LIMIT;
  assign squash       = redirect_i | flush_i;

  // IF/ID next state: squash > stall > capture; out-of-range fetches become bubbles.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (squash) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!stall_i) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = out_of_range ? NOP_INSTR : imem_instruction_i;
      ifid_valid_d = ~out_of_range;
    end
  end

  // Fault only counts fetches actually consumed, so a held or squashed fetch cannot re-fire it.
  always_comb begin
    fault_d = misaligned | (out_of_range & ~squash & ~stall_i);
  end

  // PC, IF/ID and fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_pc_o     = pc_q;
  assign ifid_pc_o     = ifid_pc_q;
  assign ifid_pc4_o    = ifid_pc_q + XLEN'(PC_STEP);
  assign ifid_instr_o  = ifid_instr_q;
  assign ifid_valid_o  = ifid_valid_q;
  assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: two instances (1024-word and 4-word memory) share stimulus
// and are compared against a cycle-level reference model of the fetch rules.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redir;
  logic [31:0] rpc;

  logic [31:0] imem_pc   [2];
  logic [31:0] imem_inst [2];
  logic [31:0] ifid_pc   [2];
  logic [31:0] ifid_pc4  [2];
  logic [31:0] ifid_inst [2];
  logic        ifid_val  [2];
  logic        fault     [2];

  logic [31:0] mem [1024];
  int unsigned words [2] = '{1024, 4};

  // Reference model state
  logic [31:0] m_pc [2], m_ipc [2], m_instr [2];
  logic        m_valid [2], m_fault [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .IMEM_WORDS(1024)) u_dut_a (
    .clk                (clk),
    .reset              (reset),
    .stall_i            (stall),
    .flush_i            (flush),
    .redirect_i         (redir),
    .redirect_pc_i      (rpc),
    .imem_instruction_i (imem_inst[0]),
    .imem_pc_o          (imem_pc[0]),
    .ifid_pc_o          (ifid_pc[0]),
    .ifid_pc4_o         (ifid_pc4[0]),
    .ifid_instr_o       (ifid_inst[0]),
    .ifid_valid_o       (ifid_val[0]),
    .fetch_fault_o      (fault[0])
  );

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .IMEM_WORDS(4)) u_dut_b (
    .clk                (clk),
    .reset              (reset),
    .stall_i            (stall),
    .flush_i            (flush),
    .redirect_i         (redir),
    .redirect_pc_i      (rpc),
    .imem_instruction_i (imem_inst[1]),
    .imem_pc_o          (imem_pc[1]),
    .ifid_pc_o          (ifid_pc[1]),
    .ifid_pc4_o         (ifid_pc4[1]),
    .ifid_instr_o       (ifid_inst[1]),
    .ifid_valid_o       (ifid_val[1]),
    .fetch_fault_o      (fault[1])
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a < 32'd4096) return mem[a[11:2]];
    return 32'hBAD0_0000 ^ a;
  endfunction

  // Combinational memory behind each instance; the 4-word instance still sees real words.
  assign imem_inst[0] = imem_word(imem_pc[0]);
  assign imem_inst[1] = imem_word(imem_pc[1]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_ipc[k] = 32'h0; m_instr[k] = NOP;
      m_valid[k] = 1'b0; m_fault[k] = 1'b0;
    end
  endtask

  // One rising edge of the fetch rules, applied to both memory sizes.
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      logic [31:0] pc;
      bit oor, sq;
      pc  = m_pc[k];
      oor = (pc >= words[k] * 4);
      sq  = redir || flush;
      m_fault[k] = (redir && rpc[1:0] != 2'b00) || (oor && !sq && !stall);
      if (sq) begin
        m_ipc[k] = pc; m_instr[k] = NOP; m_valid[k] = 1'b0;
      end else if (!stall) begin
        m_ipc[k] = pc; m_instr[k] = oor ? NOP : imem_word(pc); m_valid[k] = !oor;
      end
      if (redir)      m_pc[k] = rpc & 32'hFFFF_FFFC;
      else if (!stall) m_pc[k] = pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      string s;
      s = $sformatf("%s[%0d]", tag, k);
      chk({s, ".imem_pc"}, imem_pc[k], m_pc[k]);
      chk({s, ".ifid_pc"}, ifid_pc[k], m_ipc[k]);
      chk({s, ".ifid_pc4"}, ifid_pc4[k], m_ipc[k] + 32'd4);
      chk({s, ".instr"}, ifid_inst[k], m_instr[k]);
      chk({s, ".valid"}, {31'b0, ifid_val[k]}, {31'b0, m_valid[k]});
      chk({s, ".fault"}, {31'b0, fault[k]}, {31'b0, m_fault[k]});
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    reset = 1'b1;
    idle();
    model_reset();

    // Reset state, then first fetch at RESET_PC without an edge
    #12;
    check_all("reset");
    chk("reset.pc4", ifid_pc4[0], 32'd4);
    chk("reset.instr", ifid_inst[0], NOP);
    reset = 1'b0;
    #1;
    chk("first_fetch", imem_pc[0], 32'h0);

    // Free run: IF/ID (0,A), (4,B)
    tick("run0");
    chk("run0.ifid_pc", ifid_pc[0], 32'h0);
    chk("run0.instr", ifid_inst[0], mem[0]);
    chk("run0.imem_pc", imem_pc[0], 32'h4);
    tick("run1");
    chk("run1.ifid_pc", ifid_pc[0], 32'h4);
    chk("run1.instr", ifid_inst[0], mem[1]);
    chk("run1.imem_pc", imem_pc[0], 32'h8);

    // Two stall cycles hold (4,B) with fetch address 8, then resume with (8,C)
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick("stall");
      chk("stall.ifid_pc", ifid_pc[0], 32'h4);
      chk("stall.instr", ifid_inst[0], mem[1]);
      chk("stall.imem_pc", imem_pc[0], 32'h8);
    end
    stall = 1'b0;
    tick("resume");
    chk("resume.ifid_pc", ifid_pc[0], 32'h8);
    chk("resume.instr", ifid_inst[0], mem[2]);
    tick("run3");
    chk("run3.imem_pc", imem_pc[0], 32'h10);

    // Redirect to 0x40 from pc 0x10: one bubble, then the target
    redir = 1'b1; rpc = 32'h40;
    tick("redir");
    chk("redir.valid", {31'b0, ifid_val[0]}, 32'h0);
    chk("redir.instr", ifid_inst[0], NOP);
    chk("redir.imem_pc", imem_pc[0], 32'h40);
    idle();
    tick("redir_tgt");
    chk("redir_tgt.ifid_pc", ifid_pc[0], 32'h40);
    chk("redir_tgt.valid", {31'b0, ifid_val[0]}, 32'h1);

    // Redirect wins over stall
    redir = 1'b1; stall = 1'b1; rpc = 32'h20;
    tick("redir_stall");
    chk("redir_stall.imem_pc", imem_pc[0], 32'h20);
    chk("redir_stall.valid", {31'b0, ifid_val[0]}, 32'h0);
    idle();
    tick("after_rs");

    // Misaligned redirect: aligned target, single-cycle fault
    redir = 1'b1; rpc = 32'h2A;
    tick("misalign");
    chk("misalign.imem_pc", imem_pc[0], 32'h28);
    chk("misalign.fault", {31'b0, fault[0]}, 32'h1);
    idle();
    tick("misalign_clr");
    chk("misalign_clr.fault", {31'b0, fault[0]}, 32'h0);

    // 4-word memory: running into pc 0x10 yields a faulting bubble
    redir = 1'b1; rpc = 32'h0;
    tick("oor_redir");
    idle();
    for (int i = 0; i < 4; i++) tick("oor_run");
    tick("oor_hit");
    chk("oor_hit.ifid_pc", ifid_pc[1], 32'h10);
    chk("oor_hit.valid", {31'b0, ifid_val[1]}, 32'h0);
    chk("oor_hit.fault", {31'b0, fault[1]}, 32'h1);
    chk("oor_hit.instr", ifid_inst[1], NOP);
    tick("oor_next");

    // PC wraps from the top of the address space
    redir = 1'b1; rpc = 32'hFFFF_FFFC;
    tick("wrap_redir");
    idle();
    tick("wrap");
    chk("wrap.imem_pc", imem_pc[0], 32'h0);

    // Async reset mid-cycle during a stall, held across an edge with pending redirect
    stall = 1'b1;
    tick("pre_areset");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("areset");
    redir = 1'b1; rpc = 32'h80;
    tick("areset_hold");
    #2;
    reset = 1'b0;
    idle();
    tick("post_reset");
    chk("post_reset.ifid_pc", ifid_pc[0], 32'h0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      redir = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 3))
        0:       rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        1:       rpc = 32'($urandom_range(0, 4095));
        2:       rpc = 32'hFF0 + 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
